// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, FSM state type, captured-transaction payload and
// the burst next-address helper for the AXI RAM slave.
package axi_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    WR_RESP
  } state_t;

  // Address-phase payload held for the life of one transaction
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    burst_t           burst;
    logic             err;
  } txn_t;

  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // Reserved burst type or an unsupported WRAP length degrades to INCR + SLVERR
  function automatic txn_t capture_txn(input logic [ID_W-1:0] id,
                                       input logic [LEN_W-1:0] len,
                                       input logic [1:0] burst);
    txn_t t;
    logic bad;
    bad     = (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
    t.id    = id;
    t.len   = len;
    t.burst = bad ? BURST_INCR : burst_t'(burst);
    t.err   = bad;
    return t;
  endfunction

  // Word index of the next beat; the caller truncates to the memory width
  function automatic logic [31:0] next_index(input logic [31:0] idx,
                                             input logic [LEN_W-1:0] len,
                                             input burst_t burst);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = 32'(len);
    unique case (burst)
      BURST_FIXED: nxt = idx;
      BURST_WRAP:  nxt = (idx & ~mask) | ((idx + 32'd1) & mask);
      default:     nxt = idx + 32'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Word-addressed RAM with per-byte write enables and a combinational read port.
// No reset: contents survive rst and are undefined at power-up.
module bram_be
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_ram_slave.sv
// Single-outstanding AXI3 slave over a byte-enabled RAM: one FSM serves either
// a read burst or a write burst at a time, reads winning simultaneous requests.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,

  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,

  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,

  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,

  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IW    = DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  state_t            state, state_d;
  txn_t              txn, txn_d;
  logic [IW-1:0]     idx, idx_d, idx_nxt, rd_idx;
  logic [LEN_W-1:0]  beat, beat_d, beat_inc;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic [ID_W-1:0]   rid_d, bid_d;
  logic [DATA_W-1:0] rdata_d, mem_rdata;
  logic [1:0]        rresp_d, bresp_d;
  logic              rlast_d, rvalid_d, wready_d, bvalid_d;
  logic [STRB_W-1:0] mem_we, mem_we_g;

  // Attribute inputs this slave does not interpret
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot, araddr,
                           awsize, awlock, awcache, awprot, awaddr, wid};

  // Address ready is a decode of the idle state so it tracks arvalid and rst at once
  assign arready = (state == IDLE) && !rst;
  assign awready = (state == IDLE) && !rst && !arvalid;

  assign idx_nxt  = IW'(next_index(32'(idx), txn.len, txn.burst));
  assign beat_inc = beat + 4'd1;

  // Look ahead to the beat being loaded so rdata is registered with no bubble
  assign rd_idx   = (state == RD_BURST) ? idx_nxt : idx;
  assign mem_we_g = rst ? '0 : mem_we;

  bram_be #(
    .ADDR_W (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_g),
    .waddr (idx),
    .wdata (wdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state;
    txn_d    = txn;
    idx_d    = idx;
    beat_d   = beat;
    cnt_d    = cnt;
    rid_d    = rid;
    rdata_d  = rdata;
    rresp_d  = rresp;
    rlast_d  = rlast;
    rvalid_d = rvalid;
    wready_d = wready;
    bid_d    = bid;
    bresp_d  = bresp;
    bvalid_d = bvalid;
    mem_we   = '0;

    unique case (state)
      IDLE: begin
        if (arvalid) begin
          txn_d   = capture_txn(arid, arlen, arburst);
          idx_d   = araddr[IW+1:2];
          beat_d  = '0;
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = RD_WAIT;
        end else if (awvalid) begin
          txn_d    = capture_txn(awid, awlen, awburst);
          idx_d    = awaddr[IW+1:2];
          beat_d   = '0;
          wready_d = 1'b1;
          state_d  = WR_DATA;
        end
      end

      RD_WAIT: begin
        if (cnt == '0) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
          rid_d    = txn.id;
          rresp_d  = txn.err ? RESP_SLVERR : RESP_OKAY;
          rlast_d  = (beat == txn.len);
          state_d  = RD_BURST;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end

      RD_BURST: begin
        if (rready) begin
          if (rlast) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            beat_d  = beat_inc;
            idx_d   = idx_nxt;
            rdata_d = mem_rdata;
            rlast_d = (beat_inc == txn.len);
          end
        end
      end

      WR_DATA: begin
        if (wvalid) begin
          mem_we = wstrb;
          idx_d  = idx_nxt;
          beat_d = beat_inc;
          if (beat == txn.len) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = txn.id;
            bresp_d  = (txn.err || !wlast) ? RESP_SLVERR : RESP_OKAY;
            state_d  = WR_RESP;
          end else if (wlast) begin
            txn_d.err = 1'b1;
          end
        end
      end

      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      txn    <= '0;
      idx    <= '0;
      beat   <= '0;
      cnt    <= '0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      wready <= 1'b0;
      bid    <= '0;
      bresp  <= '0;
      bvalid <= 1'b0;
    end else begin
      state  <= state_d;
      txn    <= txn_d;
      idx    <= idx_d;
      beat   <= beat_d;
      cnt    <= cnt_d;
      rid    <= rid_d;
      rdata  <= rdata_d;
      rresp  <= rresp_d;
      rlast  <= rlast_d;
      rvalid <= rvalid_d;
      wready <= wready_d;
      bid    <= bid_d;
      bresp  <= bresp_d;
      bvalid <= bvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave (READ_LAT=4 instance).
module tb_axi_ram_slave;

  localparam int unsigned RL = 4;

  logic        clk, rst;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int vec  = 0;
  int errs = 0;

  logic [31:0] wdat [16];
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  int          rd_k    [16];
  int          rd_beats, rd_first, rd_stable_err, rd_aw_hi;

  axi_ram_slave #(.DEPTH_LOG2(12), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full write burst: AW, len+1 W beats from wdat[], then B; bad_last flips wlast on that beat
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int bad_last);
    int n;
    wr_resp = 2'bxx;
    wr_id   = 4'bxxxx;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    #1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wdat[i]; wstrb = strb; wlast = (i == int'(len)) ^ (i == bad_last); wvalid = 1'b1;
      #1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (bvalid === 1'b1) begin wr_resp = bresp; wr_id = bid; end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Full read burst; records beats, cycle of each beat, hold stability and awready seen high
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat);
    int n, k, stalls;
    logic hold, p_last;
    logic [31:0] p_data;
    logic [3:0] p_id;
    logic [1:0] p_resp;
    rd_beats = 0; rd_first = -1; rd_stable_err = 0; rd_aw_hi = 0; stalls = 0; hold = 1'b0;
    p_data = '0; p_last = 1'b0; p_id = '0; p_resp = '0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin
      if (awready === 1'b1) rd_aw_hi++;
      @(posedge clk); #1; n++;
    end
    if (awready === 1'b1) rd_aw_hi++;
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    while (rd_beats <= int'(len) && k < 200) begin
      rready = !(rd_beats == stall_beat && stalls < 2);
      #1;
      if (awready === 1'b1) rd_aw_hi++;
      if (hold && (rvalid !== 1'b1 || rdata !== p_data || rlast !== p_last ||
                   rid !== p_id || rresp !== p_resp)) rd_stable_err++;
      if (rvalid === 1'b1 && rd_first < 0) rd_first = k;
      hold = (rvalid === 1'b1) && !rready;
      p_data = rdata; p_last = rlast; p_id = rid; p_resp = rresp;
      if (rvalid === 1'b1 && !rready) stalls++;
      if (rvalid === 1'b1 && rready) begin
        rd_data[rd_beats] = rdata; rd_last[rd_beats] = rlast;
        rd_resp[rd_beats] = rresp; rd_id[rd_beats] = rid; rd_k[rd_beats] = k;
        rd_beats++;
      end
      @(posedge clk); #1;
      k++;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if ({arready, awready, rvalid, wready, bvalid, rlast} !== 6'b0) begin
      errs++; $display("FAIL reset_flags: got %b required 000000", {arready, awready, rvalid, wready, bvalid, rlast});
    end
    vec++; if ({rid, rdata, rresp, bid, bresp} !== 44'h0) begin
      errs++; $display("FAIL reset_payload: got %h required 0", {rid, rdata, rresp, bid, bresp});
    end
    rst = 1'b0;
    #1;
    vec++; if ({arready, awready} !== 2'b11) begin
      errs++; $display("FAIL reset_release_ready: got %b required 11", {arready, awready});
    end
  endtask

  task automatic test_incr();
    logic [31:0] exp;
    int bad_d, bad_l, bad_k;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wdat[i] = 32'(i) * 32'h1111_1111;
    do_write(4'h5, 32'h0000_1000, 4'd15, 2'b01, 4'hF, -1);
    vec++; if (wr_resp !== 2'b00) begin errs++; $display("FAIL incr_bresp: got %b required 00", wr_resp); end
    vec++; if (wr_id !== 4'h5) begin errs++; $display("FAIL incr_bid: got %h required 5", wr_id); end
    do_read(4'h3, 32'h0000_1000, 4'd15, 2'b01, -1);
    vec++; if (rd_beats !== 16) begin errs++; $display("FAIL incr_beats: got %0d required 16", rd_beats); end
    vec++; if (rd_first !== int'(RL)) begin errs++; $display("FAIL read_latency: got %0d required %0d", rd_first, RL); end
    bad_d = 0; bad_l = 0; bad_k = 0;
    for (int i = 0; i < rd_beats; i++) begin
      exp = 32'(i) * 32'h1111_1111;
      if (rd_data[i] !== exp || rd_id[i] !== 4'h3 || rd_resp[i] !== 2'b00) bad_d++;
      if (rd_last[i] !== (i == 15)) bad_l++;
      if (rd_k[i] !== rd_first + i) bad_k++;
    end
    vec++; if (bad_d !== 0) begin errs++; $display("FAIL incr_data: %0d bad beats, required 0", bad_d); end
    vec++; if (bad_l !== 0) begin errs++; $display("FAIL incr_rlast: %0d bad beats, required 0", bad_l); end
    vec++; if (bad_k !== 0) begin errs++; $display("FAIL incr_back_to_back: %0d gaps, required 0", bad_k); end
    do_read(4'h1, 32'h0000_5004, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h1111_1111 || rd_last[0] !== 1'b1) begin
      errs++; $display("FAIL alias_read: got %h last %b required 11111111 last 1", rd_data[0], rd_last[0]);
    end
    wdat[0] = 32'h1234_5678; wdat[1] = 32'h9ABC_DEF0;
    do_write(4'h2, 32'h0000_3FFC, 4'd1, 2'b01, 4'hF, -1);
    do_read(4'h2, 32'h0000_0000, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h9ABC_DEF0) begin
      errs++; $display("FAIL incr_modulo_wrap: got %h required 9abcdef0", rd_data[0]);
    end
  endtask

  task automatic test_bursts();
    do_read(4'h6, 32'h0000_1008, 4'd3, 2'b10, -1);
    vec++; if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !==
               {32'h2222_2222, 32'h3333_3333, 32'h0000_0000, 32'h1111_1111}) begin
      errs++; $display("FAIL wrap_read: got %h %h %h %h required 22222222 33333333 00000000 11111111",
                       rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    vec++; if (rd_resp[0] !== 2'b00 || rd_last[3] !== 1'b1) begin
      errs++; $display("FAIL wrap_resp_last: got resp %b last %b required 00 1", rd_resp[0], rd_last[3]);
    end
    do_read(4'h6, 32'h0000_1008, 4'd2, 2'b00, -1);
    vec++; if ({rd_data[0], rd_data[1], rd_data[2]} !== {3{32'h2222_2222}}) begin
      errs++; $display("FAIL fixed_read: got %h %h %h required 22222222 x3", rd_data[0], rd_data[1], rd_data[2]);
    end
    do_read(4'h9, 32'h0000_1004, 4'd1, 2'b11, -1);
    vec++; if ({rd_resp[0], rd_resp[1]} !== 4'b1010 || {rd_data[0], rd_data[1]} !== {32'h1111_1111, 32'h2222_2222}) begin
      errs++; $display("FAIL burst11_read: got resp %b%b data %h %h required 1010 11111111 22222222",
                       rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
    end
    do_read(4'h9, 32'h0000_1004, 4'd2, 2'b10, -1);
    vec++; if (rd_resp[0] !== 2'b10 || rd_data[2] !== 32'h3333_3333) begin
      errs++; $display("FAIL bad_wrap_len: got resp %b data %h required 10 33333333", rd_resp[0], rd_data[2]);
    end
  endtask

  task automatic test_strobe();
    wdat[0] = 32'h0;
    do_write(4'h1, 32'h0000_0020, 4'd0, 2'b01, 4'hF, -1);
    wdat[0] = 32'hAABB_CCDD;
    do_write(4'h1, 32'h0000_0020, 4'd0, 2'b01, 4'b0101, -1);
    do_read(4'h1, 32'h0000_0020, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h00BB_00DD) begin
      errs++; $display("FAIL strobe_0101: got %h required 00bb00dd", rd_data[0]);
    end
    wdat[0] = 32'hFFFF_FFFF;
    do_write(4'h1, 32'h0000_0020, 4'd0, 2'b01, 4'b0000, -1);
    vec++; if (wr_resp !== 2'b00) begin errs++; $display("FAIL strobe_zero_bresp: got %b required 00", wr_resp); end
    do_read(4'h1, 32'h0000_0020, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h00BB_00DD) begin
      errs++; $display("FAIL strobe_0000: got %h required 00bb00dd", rd_data[0]);
    end
  endtask

  task automatic test_arbitration();
    awid = 4'h7; awaddr = 32'h0000_0040; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
    do_read(4'h4, 32'h0000_1000, 4'd3, 2'b01, 1);
    vec++; if (rd_aw_hi !== 0) begin errs++; $display("FAIL arb_awready_during_read: high %0d samples required 0", rd_aw_hi); end
    vec++; if (rd_beats !== 4 || rd_data[3] !== 32'h3333_3333 || rd_id[0] !== 4'h4) begin
      errs++; $display("FAIL arb_read_first: got beats %0d data %h id %h required 4 33333333 4", rd_beats, rd_data[3], rd_id[0]);
    end
    vec++; if (rd_stable_err !== 0 || rd_data[1] !== 32'h1111_1111 || rd_data[2] !== 32'h2222_2222) begin
      errs++; $display("FAIL stall_hold: unstable %0d data %h %h required 0 11111111 22222222",
                       rd_stable_err, rd_data[1], rd_data[2]);
    end
    #1;
    vec++; if (awready !== 1'b1) begin errs++; $display("FAIL arb_awready_after_read: got %b required 1", awready); end
    wdat[0] = 32'hCAFE_F00D;
    do_write(4'h7, 32'h0000_0040, 4'd0, 2'b01, 4'hF, -1);
    vec++; if (wr_id !== 4'h7 || wr_resp !== 2'b00) begin
      errs++; $display("FAIL arb_write_after: got bid %h bresp %b required 7 00", wr_id, wr_resp);
    end
    do_read(4'h0, 32'h0000_0040, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'hCAFE_F00D) begin errs++; $display("FAIL arb_write_data: got %h required cafef00d", rd_data[0]); end
  endtask

  task automatic test_wlast();
    wdat[0] = 32'h0101_0101; wdat[1] = 32'h0202_0202;
    do_write(4'hA, 32'h0000_0080, 4'd1, 2'b01, 4'hF, 0);
    vec++; if (wr_resp !== 2'b10 || wr_id !== 4'hA) begin
      errs++; $display("FAIL wlast_early: got bresp %b bid %h required 10 a", wr_resp, wr_id);
    end
    do_write(4'hB, 32'h0000_0080, 4'd1, 2'b01, 4'hF, 1);
    vec++; if (wr_resp !== 2'b10) begin errs++; $display("FAIL wlast_missing: got bresp %b required 10", wr_resp); end
    do_write(4'hC, 32'h0000_0080, 4'd1, 2'b01, 4'hF, -1);
    vec++; if (wr_resp !== 2'b00) begin errs++; $display("FAIL wlast_clean: got bresp %b required 00", wr_resp); end
  endtask

  task automatic test_rst_mid();
    int n, beats, hi;
    logic hit;
    arid = 4'h2; araddr = 32'h0000_1000; arlen = 4'd15; arburst = 2'b01; arvalid = 1'b1;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0; beats = 0; hit = 1'b0;
    while (n < 100 && !hit) begin
      #1;
      if (rvalid === 1'b1) begin
        if (beats == 5) begin hit = 1'b1; rst = 1'b1; end
        else beats++;
      end
      if (!hit) begin @(posedge clk); #1; end
      n++;
    end
    @(posedge clk); #1;
    vec++; if (hit !== 1'b1 || rvalid !== 1'b0 || arready !== 1'b0) begin
      errs++; $display("FAIL rst_mid_burst: reached %b rvalid %b arready %b required 1 0 0", hit, rvalid, arready);
    end
    rst = 1'b0; rready = 1'b0;
    #1;
    vec++; if (arready !== 1'b1) begin errs++; $display("FAIL rst_release_arready: got %b required 1", arready); end
    hi = 0;
    repeat (4) begin @(posedge clk); #1; if (rvalid !== 1'b0 || bvalid !== 1'b0) hi++; end
    vec++; if (hi !== 0) begin errs++; $display("FAIL rst_no_stray_beats: %0d cycles with valid, required 0", hi); end
    do_read(4'h2, 32'h0000_1010, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h4444_4444) begin errs++; $display("FAIL rst_mem_kept: got %h required 44444444", rd_data[0]); end
    do_read(4'h2, 32'h0000_0020, 4'd0, 2'b01, -1);
    vec++; if (rd_data[0] !== 32'h00BB_00DD) begin errs++; $display("FAIL rst_mem_kept2: got %h required 00bb00dd", rd_data[0]); end
  endtask

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 16; i++) wdat[i] = '0;
    test_reset();
    test_incr();
    test_bursts();
    test_strobe();
    test_arbitration();
    test_wlast();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
